fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 121 ++++++++++++
 tb/tb_fetch_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch/decode sequencer: fetches a word at PC, optionally resolves
// one level of indirection, then holds EXEC until the execute unit finishes.
module fetch_seq #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int OPC_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              exec_done,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ar,
  output logic [DATA_W-1:0] ir,
  output logic              i_bit,
  output logic [OPC_W-1:0]  opcode,
  output logic              dec_valid,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    RD_I     = 3'd2,
    DECODE   = 3'd3,
    INDIRECT = 3'd4,
    EXEC     = 3'd5
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] ar_reg;
  logic [DATA_W-1:0] ir_reg;
  logic              i_bit_reg;
  logic              mem_req_reg;
  logic              dec_valid_reg;

  // Opcode all-ones marks an I/O-style instruction whose address field is not a pointer.
  logic go_indirect;
  assign go_indirect = ir_reg[DATA_W-1] && !(&ir_reg[DATA_W-2 -: OPC_W]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      ar_reg        <= '0;
      ir_reg        <= '0;
      i_bit_reg     <= 1'b0;
      mem_req_reg   <= 1'b0;
      dec_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= FETCH;
        end
        FETCH: begin
          ar_reg      <= pc_reg;
          mem_req_reg <= 1'b1;
          state_reg   <= RD_I;
        end
        RD_I: begin
          if (mem_ack) begin
            ir_reg      <= mem_rdata;
            pc_reg      <= pc_reg + 1'b1;
            mem_req_reg <= 1'b0;
            state_reg   <= DECODE;
          end
        end
        DECODE: begin
          i_bit_reg <= ir_reg[DATA_W-1];
          ar_reg    <= ir_reg[ADDR_W-1:0];
          if (go_indirect) begin
            mem_req_reg <= 1'b1;
            state_reg   <= INDIRECT;
          end else begin
            dec_valid_reg <= 1'b1;
            state_reg     <= EXEC;
          end
        end
        INDIRECT: begin
          if (mem_ack) begin
            ar_reg        <= mem_rdata[ADDR_W-1:0];
            mem_req_reg   <= 1'b0;
            dec_valid_reg <= 1'b1;
            state_reg     <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done) begin
            if (branch_en) pc_reg <= branch_addr;
            dec_valid_reg <= 1'b0;
            state_reg     <= halt ? IDLE : FETCH;
          end
        end
        default: begin
          mem_req_reg   <= 1'b0;
          dec_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_addr  = ar_reg;
  assign pc        = pc_reg;
  assign ar        = ar_reg;
  assign ir        = ir_reg;
  assign i_bit     = i_bit_reg;
  assign opcode    = ir_reg[DATA_W-2 -: OPC_W];
  assign dec_valid = dec_valid_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: memory responder with programmable wait states
// and a scoreboard of expected decoded results popped when EXEC is reached.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        exec_done = 1'b0;
  logic        branch_en = 1'b0;
  logic [11:0] branch_addr = '0;
  logic        halt = 1'b0;
  logic [11:0] pc, ar;
  logic [15:0] ir;
  logic        i_bit;
  logic [2:0]  opcode;
  logic        dec_valid;
  logic [2:0]  state;

  fetch_seq #(.ADDR_W(12), .DATA_W(16), .OPC_W(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .exec_done(exec_done), .branch_en(branch_en), .branch_addr(branch_addr), .halt(halt),
    .pc(pc), .ar(ar), .ir(ir), .i_bit(i_bit), .opcode(opcode),
    .dec_valid(dec_valid), .state(state)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  int ack_delay = 0;
  int wcnt = 0;
  bit stray_ack = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] ir;
    logic [11:0] pc;
    logic [11:0] ar;
    logic        ib;
    logic [2:0]  op;
  } exp_t;
  exp_t sb[$];

  // Memory responder: acts 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stray_ack) begin
        mem_ack = 1'b1;
      end else if (mem_req && !mem_ack) begin
        if (wcnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wcnt      = 0;
        end else begin
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input logic [2:0] s, output int cycles, output bit saw_ind);
    cycles  = 0;
    saw_ind = 1'b0;
    while (state !== s && cycles < 40) begin
      step();
      cycles++;
      if (state === 3'd4) saw_ind = 1'b1;
    end
    check($sformatf("reach_state_%0d", s), {29'd0, state}, {29'd0, s});
  endtask

  task automatic check_exec(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      $display("[TB] %s: ir=%04h pc=%03h ar=%03h i=%0b op=%0d", tag, ir, pc, ar, i_bit, opcode);
      check({tag, "_ir"}, {16'd0, ir}, {16'd0, e.ir});
      check({tag, "_pc"}, {20'd0, pc}, {20'd0, e.pc});
      check({tag, "_ar"}, {20'd0, ar}, {20'd0, e.ar});
      check({tag, "_ibit"}, {31'd0, i_bit}, {31'd0, e.ib});
      check({tag, "_op"}, {29'd0, opcode}, {29'd0, e.op});
      check({tag, "_dv"}, {31'd0, dec_valid}, 32'd1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_fetch", {29'd0, state}, 32'd1);
  endtask

  task automatic finish_exec(input logic br, input logic [11:0] baddr, input logic h);
    exec_done = 1'b1; branch_en = br; branch_addr = baddr; halt = h;
    step();
    exec_done = 1'b0; branch_en = 1'b0; halt = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  ind;
    exp_t e;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h000] = 16'h2005;
    mem[12'hFFF] = 16'h0003;
    mem[12'h100] = 16'h8010;
    mem[12'h010] = 16'h0ABC;
    mem[12'h101] = 16'hF001;
    mem[12'h102] = 16'h3123;
    mem[12'h103] = 16'h8020;

    // Reset state, observed before the first clock edge.
    #2;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", {20'd0, pc}, 32'd0);
    check("rst_ar", {20'd0, ar}, 32'd0);
    check("rst_ir", {16'd0, ir}, 32'd0);
    check("rst_ibit", {31'd0, i_bit}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_dv", {31'd0, dec_valid}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("idle_hold", {29'd0, state}, 32'd0);

    // Direct fetch from 0x000, zero-wait ack.
    e = '{ir:16'h2005, pc:12'h001, ar:12'h005, ib:1'b0, op:3'd2}; sb.push_back(e);
    pulse_start();
    wait_state(3'd5, cyc, ind);
    check("direct_latency", cyc, 32'd3);
    check("direct_no_ind", {31'd0, ind}, 32'd0);
    check_exec("direct");

    // Branch to 0xFFF: PC wraps to 0x000 after the fetch.
    e = '{ir:16'h0003, pc:12'h000, ar:12'h003, ib:1'b0, op:3'd0}; sb.push_back(e);
    finish_exec(1'b1, 12'hFFF, 1'b0);
    check("branch_fetch", {29'd0, state}, 32'd1);
    step();
    check("branch_rdi_addr", {20'd0, mem_addr}, 32'hFFF);
    wait_state(3'd5, cyc, ind);
    check_exec("wrap");

    // Branch together with halt: both take effect.
    finish_exec(1'b1, 12'h100, 1'b1);
    check("brhalt_state", {29'd0, state}, 32'd0);
    check("brhalt_pc", {20'd0, pc}, 32'h100);

    // Indirect fetch through 0x010.
    e = '{ir:16'h8010, pc:12'h101, ar:12'hABC, ib:1'b1, op:3'd0}; sb.push_back(e);
    pulse_start();
    wait_state(3'd4, cyc, ind);
    check("ind_addr", {20'd0, mem_addr}, 32'h010);
    check("ind_req", {31'd0, mem_req}, 32'd1);
    wait_state(3'd5, cyc, ind);
    check("ind_latency_tail", cyc, 32'd1);
    check_exec("indirect");

    // Opcode all-ones with I=1 skips the indirect cycle.
    e = '{ir:16'hF001, pc:12'h102, ar:12'h001, ib:1'b1, op:3'd7}; sb.push_back(e);
    finish_exec(1'b0, 12'h0AA, 1'b0);
    wait_state(3'd5, cyc, ind);
    check("op7_latency", cyc, 32'd3);
    check("op7_no_ind", {31'd0, ind}, 32'd0);
    check_exec("op7");

    // Three wait states in RD_I: request and address held steady.
    ack_delay = 3;
    e = '{ir:16'h3123, pc:12'h103, ar:12'h123, ib:1'b0, op:3'd3}; sb.push_back(e);
    finish_exec(1'b0, 12'h0AA, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("wait_state_%0d", k), {29'd0, state}, 32'd2);
      check($sformatf("wait_req_%0d", k), {31'd0, mem_req}, 32'd1);
      check($sformatf("wait_addr_%0d", k), {20'd0, mem_addr}, 32'h102);
    end
    wait_state(3'd5, cyc, ind);
    check_exec("waits");
    ack_delay = 0;
    finish_exec(1'b0, 12'h0AA, 1'b1);
    check("halt_idle", {29'd0, state}, 32'd0);

    // Execute-side inputs and a stray ack are ignored in IDLE.
    exec_done = 1'b1; branch_en = 1'b1; branch_addr = 12'h555; halt = 1'b1; stray_ack = 1'b1;
    step();
    step();
    exec_done = 1'b0; branch_en = 1'b0; halt = 1'b0; stray_ack = 1'b0;
    check("idle_ign_state", {29'd0, state}, 32'd0);
    check("idle_ign_pc", {20'd0, pc}, 32'h103);
    step();

    // Asynchronous reset in the middle of INDIRECT.
    ack_delay = 20;
    pulse_start();
    wait_state(3'd4, cyc, ind);
    #1;
    reset = 1'b1;
    #1;
    check("areset_state", {29'd0, state}, 32'd0);
    check("areset_req", {31'd0, mem_req}, 32'd0);
    check("areset_pc", {20'd0, pc}, 32'd0);
    check("areset_ar", {20'd0, ar}, 32'd0);
    check("areset_ir", {16'd0, ir}, 32'd0);
    check("areset_ibit", {31'd0, i_bit}, 32'd0);
    check("areset_dv", {31'd0, dec_valid}, 32'd0);
    step();
    reset = 1'b0;
    ack_delay = 0;
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    step();
    check("post_rst_state", {29'd0, state}, 32'd0);
    check("post_rst_ir", {16'd0, ir}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
